// File: rtl/ps2_pkg.sv
// ps2_pkg: shared PS/2 receiver constants and frame FSM state encoding
package ps2_pkg;
  localparam int DATA_BITS  = 8;
  localparam int FRAME_BITS = 11;
  typedef enum logic [1:0] {IDLE, DATA, PARITY, STOP} state_e;
endpackage

// File: rtl/ps2_byte_fifo.sv
// ps2_byte_fifo: first-word fall-through byte FIFO with occupancy count
module ps2_byte_fifo #(
  parameter int DEPTH = 8
) (
  input  logic                       clk,
  input  logic                       resetn,
  input  logic                       push_i,
  input  logic                       pop_i,
  input  logic [7:0]                 wdata_i,
  output logic [7:0]                 rdata_o,
  output logic                       full_o,
  output logic                       empty_o,
  output logic [$clog2(DEPTH+1)-1:0] level_o
);
  localparam int AW = $clog2(DEPTH);
  localparam int LW = $clog2(DEPTH+1);
  logic [7:0]    mem_q [DEPTH];
  logic [AW-1:0] wr_q, rd_q;
  logic [LW-1:0] cnt_q;
  logic          do_push, do_pop;
  assign empty_o = cnt_q == '0;
  assign full_o  = cnt_q == LW'(DEPTH);
  assign level_o = cnt_q;
  assign do_pop  = pop_i & ~empty_o;
  // a pop in the same cycle frees the slot a full-FIFO push needs
  assign do_push = push_i & (~full_o | do_pop);
  assign rdata_o = empty_o ? 8'h00 : mem_q[rd_q];
  always_ff @(posedge clk)
    if (do_push) mem_q[wr_q] <= wdata_i;
  always_ff @(posedge clk) begin
    if (!resetn) begin
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
    end else begin
      if (do_push) wr_q <= wr_q + 1'b1;
      if (do_pop) rd_q <= rd_q + 1'b1;
      cnt_q <= cnt_q + LW'(do_push) - LW'(do_pop);
    end
  end
endmodule

// File: rtl/ps2_rx_fifo.sv
// ps2_rx_fifo: PS/2 device-to-host frame receiver with glitch filtering,
// timeout abort, sticky error flags and a byte FIFO.
module ps2_rx_fifo
  import ps2_pkg::*;
#(
  parameter int FIFO_DEPTH     = 8,
  parameter int FILTER_LEN     = 4,
  parameter int TIMEOUT_CYCLES = 50000
) (
  input  logic                            clk,
  input  logic                            resetn,
  input  logic                            ps2_clk,
  input  logic                            ps2_data,
  input  logic                            enable,
  input  logic                            rd_en,
  input  logic                            clr_err,
  output logic [7:0]                      rd_data,
  output logic                            rd_valid,
  output logic [$clog2(FIFO_DEPTH+1)-1:0] level,
  output logic                            overflow,
  output logic                            parity_err,
  output logic                            frame_err
);
  localparam int FW = $clog2(FILTER_LEN+1);
  localparam int TW = $clog2(TIMEOUT_CYCLES+1);
  localparam int BW = $clog2(DATA_BITS);
  logic [1:0]           line, s1_q, s2_q, filt_q;
  logic [FW-1:0]        cnt_q [2];
  logic                 clk_prev_q, fall, bit_in;
  state_e               state_q;
  logic [BW-1:0]        bit_cnt_q;
  logic [DATA_BITS-1:0] shift_q;
  logic                 par_q, par_ok, stop_edge, start_bad, timeout, push, full, empty;
  logic [TW-1:0]        to_q;
  logic                 overflow_q, parity_err_q, frame_err_q;
  assign line = {ps2_data, ps2_clk};
  // index 0 is the clock line, index 1 the data line; both idle high
  for (genvar i = 0; i < 2; i++) begin : g_filt
    always_ff @(posedge clk) begin
      if (!resetn) begin
        s1_q[i]   <= 1'b1;
        s2_q[i]   <= 1'b1;
        filt_q[i] <= 1'b1;
        cnt_q[i]  <= '0;
      end else begin
        s1_q[i] <= line[i];
        s2_q[i] <= s1_q[i];
        if (s2_q[i] == filt_q[i]) cnt_q[i] <= '0;
        else if (cnt_q[i] == FW'(FILTER_LEN-1)) begin
          filt_q[i] <= s2_q[i];
          cnt_q[i]  <= '0;
        end else cnt_q[i] <= cnt_q[i] + 1'b1;
      end
    end
  end
  assign fall      = clk_prev_q & ~filt_q[0];
  assign bit_in    = filt_q[1];
  assign par_ok    = ^{shift_q, par_q};
  assign stop_edge = enable & (state_q == STOP) & fall;
  assign start_bad = enable & (state_q == IDLE) & fall & bit_in;
  assign timeout   = enable & (state_q != IDLE) & ~fall & (to_q == TW'(TIMEOUT_CYCLES-1));
  assign push      = stop_edge & bit_in & par_ok;
  always_ff @(posedge clk) begin
    if (!resetn) begin
      clk_prev_q   <= 1'b1;
      state_q      <= IDLE;
      bit_cnt_q    <= '0;
      shift_q      <= '0;
      par_q        <= 1'b0;
      to_q         <= '0;
      overflow_q   <= 1'b0;
      parity_err_q <= 1'b0;
      frame_err_q  <= 1'b0;
    end else begin
      clk_prev_q   <= filt_q[0];
      overflow_q   <= (overflow_q & ~clr_err) | (push & full & ~rd_en);
      parity_err_q <= (parity_err_q & ~clr_err) | (stop_edge & ~par_ok);
      frame_err_q  <= (frame_err_q & ~clr_err) | start_bad | (stop_edge & ~bit_in) | timeout;
      to_q         <= (state_q == IDLE || fall) ? '0 : to_q + 1'b1;
      if (!enable || timeout) state_q <= IDLE;
      else if (fall)
        case (state_q)
          IDLE: if (!bit_in) begin
            state_q   <= DATA;
            bit_cnt_q <= '0;
          end
          DATA: begin
            shift_q   <= {bit_in, shift_q[DATA_BITS-1:1]};
            bit_cnt_q <= bit_cnt_q + 1'b1;
            if (bit_cnt_q == BW'(DATA_BITS-1)) state_q <= PARITY;
          end
          PARITY: begin
            par_q   <= bit_in;
            state_q <= STOP;
          end
          default: state_q <= IDLE;
        endcase
    end
  end
  ps2_byte_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
    .clk     (clk),
    .resetn  (resetn),
    .push_i  (push),
    .pop_i   (rd_en),
    .wdata_i (shift_q),
    .rdata_o (rd_data),
    .full_o  (full),
    .empty_o (empty),
    .level_o (level)
  );
  assign rd_valid   = ~empty;
  assign overflow   = overflow_q;
  assign parity_err = parity_err_q;
  assign frame_err  = frame_err_q;
endmodule

// File: tb/tb_ps2_rx_fifo.sv
// tb_ps2_rx_fifo: directed-frame bench for the PS/2 receiver and its FIFO
`timescale 1ns/1ps
module tb_ps2_rx_fifo;
  localparam int H = 20;
  localparam int TO = 200;
  logic       clk = 0, resetn, ps2_clk, ps2_data, enable, rd_en, clr_err;
  logic [7:0] rd_data;
  logic       rd_valid, overflow, parity_err, frame_err;
  logic [3:0] level;
  int         n_checks = 0, n_errors = 0;
  ps2_rx_fifo #(.FIFO_DEPTH(8), .FILTER_LEN(4), .TIMEOUT_CYCLES(TO)) dut (
    .clk        (clk),
    .resetn     (resetn),
    .ps2_clk    (ps2_clk),
    .ps2_data   (ps2_data),
    .enable     (enable),
    .rd_en      (rd_en),
    .clr_err    (clr_err),
    .rd_data    (rd_data),
    .rd_valid   (rd_valid),
    .level      (level),
    .overflow   (overflow),
    .parity_err (parity_err),
    .frame_err  (frame_err)
  );
  // 500 kHz system clock; 2*H cycles per PS/2 bit gives 12.5 kHz
  always #1000 clk = ~clk;
  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask
  task automatic wait_cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask
  task automatic send(input logic [7:0] d, input logic par, input logic stp, input int nbits,
                      input bit glitch, input bit pop_stop);
    logic [10:0] bits;
    bit          found;
    bits = {stp, par, d, 1'b0};
    for (int i = 0; i < nbits; i++) begin
      ps2_data = bits[i];
      if (glitch && i > 0) begin
        wait_cyc(H/2);
        ps2_clk = 0;
        wait_cyc(2);
        ps2_clk = 1;
        wait_cyc(H/2 - 2);
      end else wait_cyc(H);
      ps2_clk = 0;
      if (pop_stop && i == 10) begin
        found = 0;
        for (int c = 0; c < H; c++) begin
          @(posedge clk);
          #1;
          if (dut.fall) begin
            found = 1;
            rd_en = 1;
            wait_cyc(1);
            rd_en = 0;
            break;
          end
        end
        check("stop_edge_seen", 32'(found), 1);
      end
      wait_cyc(H);
      ps2_clk = 1;
    end
    wait_cyc(H);
    ps2_data = 1;
  endtask
  task automatic pop_check(input string tag, input logic [7:0] exp);
    check(tag, rd_data, exp);
    rd_en = 1;
    wait_cyc(1);
    rd_en = 0;
  endtask
  task automatic clear_errors();
    clr_err = 1;
    wait_cyc(1);
    clr_err = 0;
  endtask
  initial begin
    resetn = 0; ps2_clk = 1; ps2_data = 1; enable = 1; rd_en = 0; clr_err = 0;
    wait_cyc(5);
    resetn = 1;
    wait_cyc(10);
    check("rst_valid", 32'(rd_valid), 0);
    check("rst_data", 32'(rd_data), 0);
    check("rst_level", 32'(level), 0);
    check("rst_flags", {overflow, parity_err, frame_err}, 0);
    send(8'h1C, 1'b0, 1'b1, 11, 0, 0);
    check("1c_valid", 32'(rd_valid), 1);
    check("1c_data", 32'(rd_data), 32'h1C);
    check("1c_level", 32'(level), 1);
    check("1c_flags", {overflow, parity_err, frame_err}, 0);
    pop_check("1c_pop", 8'h1C);
    check("1c_empty", 32'(level), 0);
    send(8'hF0, 1'b0, 1'b1, 11, 0, 0);
    check("par_level", 32'(level), 0);
    check("par_err", 32'(parity_err), 1);
    check("par_frame", 32'(frame_err), 0);
    clear_errors();
    check("par_clr", 32'(parity_err), 0);
    for (int b = 1; b <= 9; b++) send(8'(b), ~^(8'(b)), 1'b1, 11, 0, 0);
    check("ovf_level", 32'(level), 8);
    check("ovf_flag", 32'(overflow), 1);
    for (int b = 1; b <= 8; b++) pop_check($sformatf("ovf_pop%0d", b), 8'(b));
    check("ovf_drained", 32'(rd_valid), 0);
    clear_errors();
    check("ovf_clr", 32'(overflow), 0);
    send(8'hA5, 1'b1, 1'b1, 5, 0, 0);
    wait_cyc(TO + 10);
    check("to_frame_err", 32'(frame_err), 1);
    check("to_level", 32'(level), 0);
    clear_errors();
    send(8'h00, 1'b1, 1'b1, 11, 0, 0);
    check("to_next_level", 32'(level), 1);
    check("to_next_flags", {overflow, parity_err, frame_err}, 0);
    pop_check("to_next_data", 8'h00);
    send(8'h5A, 1'b1, 1'b1, 11, 1, 0);
    check("gl_level", 32'(level), 1);
    check("gl_flags", {overflow, parity_err, frame_err}, 0);
    pop_check("gl_data", 8'h5A);
    send(8'h3C, 1'b1, 1'b0, 11, 0, 0);
    check("stop_bad_level", 32'(level), 0);
    check("stop_bad_ferr", 32'(frame_err), 1);
    clear_errors();
    for (int b = 16; b < 24; b++) send(8'(b), ~^(8'(b)), 1'b1, 11, 0, 0);
    check("full_level", 32'(level), 8);
    send(8'h18, ~^(8'h18), 1'b1, 11, 0, 1);
    check("fp_level", 32'(level), 8);
    check("fp_ovf", 32'(overflow), 0);
    for (int b = 17; b <= 24; b++) pop_check($sformatf("fp_pop%0d", b), 8'(b));
    check("fp_empty", 32'(level), 0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule

// File: doc/ps2_rx_fifo.md
PS2_RX_FIFO -- requirements
Module: ps2_rx_fifo

Interface
REQ-001 SHALL have parameter FIFO_DEPTH, default 8, number of received bytes buffered (power of two, 2..64).
REQ-002 SHALL have parameter FILTER_LEN, default 4, consecutive equal clk samples required to accept a PS/2 line level.
REQ-003 SHALL have parameter TIMEOUT_CYCLES, default 50000, clk cycles without a PS/2 falling edge before a frame in progress is aborted.
REQ-004 SHALL have port clk  input  1  system clock; all logic on rising edge.
REQ-005 SHALL have port resetn  input  1  synchronous, active-low reset.
REQ-006 SHALL have port ps2_clk  input  1  asynchronous PS/2 clock line.
REQ-007 SHALL have port ps2_data  input  1  asynchronous PS/2 data line.
REQ-008 SHALL have port enable  input  1  receiver enable; low holds the frame FSM in IDLE.
REQ-009 SHALL have port rd_en  input  1  pop request for the FIFO head.
REQ-010 SHALL have port clr_err  input  1  clears sticky error flags.
REQ-011 SHALL have port rd_data  output  8  FIFO head byte (first-word fall-through).
REQ-012 SHALL have port rd_valid  output  1  FIFO not empty.
REQ-013 SHALL have port level  output  $clog2(FIFO_DEPTH+1)  current FIFO occupancy.
REQ-014 SHALL have port overflow  output  1  sticky: byte dropped because the FIFO was full.
REQ-015 SHALL have port parity_err  output  1  sticky: odd-parity check failed.
REQ-016 SHALL have port frame_err  output  1  sticky: bad start/stop bit or timeout.

Function
REQ-017 Both PS/2 lines SHALL pass a 2-flop synchronizer, then a FILTER_LEN-sample glitch filter; filtered level changes only after FILTER_LEN identical samples.
REQ-018 A falling edge SHALL be a filtered ps2_clk transition 1->0, flagged for exactly one clk cycle; filtered ps2_data is sampled in that cycle.
REQ-019 FSM states SHALL be IDLE, DATA, PARITY, STOP.
REQ-020 IDLE: edge with data=0 -> DATA, bit counter=0; edge with data=1 -> stay IDLE, set frame_err.
REQ-021 DATA: shift bits LSB first; after the 8th edge -> PARITY.
REQ-022 PARITY: record parity bit; -> STOP on next edge.
REQ-023 STOP: on edge, push byte iff stop=1 and data plus parity have an odd count of ones; stop=0 sets frame_err; parity mismatch sets parity_err; both may set together; always -> IDLE.
REQ-024 Push SHALL occur in the cycle the stop edge is flagged; rd_valid and rd_data SHALL update the following cycle.
REQ-025 In any non-IDLE state, TIMEOUT_CYCLES cycles without an edge SHALL abort to IDLE, discard the partial byte, and set frame_err; the counter reloads on every edge.
REQ-026 enable low SHALL force IDLE next cycle and discard any partial frame without error; FIFO contents and flags are retained.
REQ-027 rd_en with rd_valid=1 SHALL pop one byte; rd_en with rd_valid=0 SHALL be ignored.
REQ-028 Push while full without pop SHALL drop the byte and set overflow; push and pop in the same cycle when full SHALL both succeed, level unchanged.
REQ-029 Push and pop in the same cycle at any level SHALL leave level unchanged; pointers wrap modulo FIFO_DEPTH.
REQ-030 clr_err SHALL clear all three sticky flags; an error event in the same cycle SHALL win (flag stays 1).

Reset
REQ-031 On resetn=0 at a clk edge: FSM=IDLE, counters=0, FIFO empty (level=0, rd_valid=0, rd_data=0), all error flags 0, filter outputs=1 (idle bus).
REQ-032 Reset mid-frame SHALL discard the frame; first frame after reset SHALL require a fresh start bit.

Structure
REQ-033 Package ps2_pkg SHALL hold the FSM state enum, DATA_BITS=8, and the ps2 frame length constant 11.
REQ-034 The FIFO SHALL be a sub-module ps2_byte_fifo (parameter DEPTH, 8-bit, FWFT, full/empty/level); synchronizer, filter, FSM, timeout stay in ps2_rx_fifo.

Verification
REQ-035 Send 0x1C (parity 0, stop 1) at 12.5 kHz PS/2 clock -> rd_valid=1, rd_data=0x1C, level=1, no flags.
REQ-036 Send 0xF0 with parity 0 -> no push, parity_err=1; then clr_err -> parity_err=0.
REQ-037 Send FIFO_DEPTH+1 bytes 0x01..0x09 with no reads -> level=8, overflow=1, pops return 0x01..0x08.
REQ-038 Stop ps2_clk after 4 data bits for TIMEOUT_CYCLES+1 cycles -> frame_err=1, FSM IDLE; following 0x00 (parity 1) frame received correctly.
REQ-039 Inject 2-cycle ps2_clk low glitches mid-frame -> ignored, byte 0x5A received intact.
REQ-040 Full FIFO, rd_en asserted in stop-edge cycle -> level stays 8, overflow=0, new byte at tail.
